alu_nibble_seq: RTL and testbench
=================================

// Module: alu_nibble_seq
// PURPOSE
//  Multi-cycle sequencer that runs a 16-bit ALU operation through a single 4-bit
//  ALU slice, one nibble per clock, LSB nibble first. It holds the ripple carry
//  between nibbles and assembles the result and flags.
//  It sits between a requester (start/ready handshake) and the shared nibble datapath.
// PARAMETERS
//  NIBBLES   4   number of nibbles per operand; data width W = 4*NIBBLES (min 1)
// PORTS
//  clk       in   1    single clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  start     in   1    request; accepted only when ready=1
//  op        in   3    opcode, sampled with start
//  a         in   W    operand A, sampled with start
//  b         in   W    operand B, sampled with start
//  ready     out  1    idle and able to accept start
//  done      out  1    one-cycle pulse: result/flags valid
//  result    out  W    assembled result, held until next accepted start
//  cout      out  1    carry out of MSB nibble (arith ops), else 0
//  ovf       out  1    signed overflow (arith ops), else 0
//  zero      out  1    result == 0
// BEHAVIOUR
//  Opcodes: 000 CLR F=0 | 001 B-A | 010 A-B | 011 A+B | 100 A^B | 101 A|B |
//   110 A&B | 111 SET F=all ones.
//  Arithmetic per nibble: F = X + Y + c; carry c0: A+B: X=A,Y=B,c0=0;
//   A-B: X=A,Y=~B,c0=1; B-A: X=B,Y=~A,c0=1. cout=1 on subtract means no borrow.
//  Logic ops and CLR/SET ignore the carry chain.
//  FSM states IDLE, RUN, DONE; nibble index idx counts 0..NIBBLES-1.
//   IDLE: ready=1. On start, latch op/a/b, clear result, load c=c0,
//    idx=0 -> RUN. start with ready=0 is ignored (no queueing).
//   RUN: ready=0. Each cycle: result[4*idx+:4]=F, c=nibble carry out, idx++.
//    After idx=NIBBLES-1 -> DONE.
//   DONE: done=1 for exactly one cycle, flags valid. Next state IDLE.
//    A start seen during DONE is ignored.
//  Latency: start sampled at edge E0 -> done high from E(NIBBLES+1) to
//   E(NIBBLES+2). With the default (4), done is high E5..E6 and ready returns at E6.
//  Flags are registered at the RUN->DONE edge and held until the next accepted start:
//   cout = final c. ovf = (X[msb]==Y[msb]) && (F[msb]!=X[msb]) on the last nibble.
//   zero = (result==0) over the full word. cout/ovf = 0 for non-arithmetic ops.
//  Reset (async, any time, including mid-RUN): state=IDLE, idx=0, c=0,
//   result=0, cout=0, ovf=0, zero=0, done=0, ready=1 once rst_n is released.
//  Latched operands are stable during RUN. Changes on a/b/op inputs do not
//   affect an operation already in flight.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_CLR..OP_SET), FSM state
//   encoding, and the NIBBLE_W=4 constant.
//  One sub-module alu_nibble: combinational 4-bit slice.
//   Inputs: x, y, cin, op. Outputs: f[3:0], cout.
//   It performs the operand swap/inversion above.
//  This top module holds the FSM, the idx counter, the carry register, the
//   operand and result registers, and the flag logic.
// TESTING
//  A+B: a=16'h00FF,b=16'h0001 -> result=16'h0100,cout=0,ovf=0,zero=0, done at E5
//  A-B: a=16'h8000,b=16'h0001 -> result=16'h7FFF,cout=1,ovf=1
//  B-A: a=16'h0005,b=16'h0003 -> result=16'hFFFE,cout=0 (borrow),ovf=0
//  Logic and constant ops:
//   XOR a=16'hA5A5,b=16'hFFFF -> 16'h5A5A.
//   SET -> 16'hFFFF. CLR -> 16'h0000 with zero=1. cout=ovf=0 for all three.
//  Handshake: start pulsed every cycle for 12 cycles -> exactly two accepted
//   ops. ready=0 and done=0 during RUN. done is high exactly 1 cycle per op.
//  Reset mid-op: drop rst_n at E2 of an add -> immediate IDLE, result=0,
//   no done. A new op after release completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: slice width, opcodes, sequencer states.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_BSA = 3'b001;  // B - A
  localparam logic [2:0] OP_SUB = 3'b010;  // A - B
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_SET = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_BSA) || (op == OP_SUB) || (op == OP_ADD);
  endfunction

  // Subtractions are done as X + ~Y + 1, so the chain starts with a carry.
  function automatic logic carry_in(input logic [2:0] op);
    return (op == OP_BSA) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit ALU slice; handles operand swap/inversion for the subtract forms.
module alu_nibble
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  input  logic [2:0]          op,
  output logic [NIBBLE_W-1:0] f,
  output logic                cout,
  output logic                ovf
);

  localparam int unsigned Msb = NIBBLE_W - 1;

  logic [NIBBLE_W-1:0] xs;
  logic [NIBBLE_W-1:0] ys;
  logic [NIBBLE_W:0]   sum;

  always_comb begin
    xs = x;
    ys = y;
    case (op)
      OP_BSA: begin
        xs = y;
        ys = ~x;
      end
      OP_SUB:  ys = ~y;
      default: ;
    endcase
  end

  assign sum = {1'b0, xs} + {1'b0, ys} + {{NIBBLE_W{1'b0}}, cin};

  always_comb begin
    f    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    if (is_arith(op)) begin
      f    = sum[NIBBLE_W-1:0];
      cout = sum[NIBBLE_W];
      // Only meaningful on the most significant nibble.
      ovf  = (xs[Msb] == ys[Msb]) && (sum[Msb] != xs[Msb]);
    end else begin
      unique case (op)
        OP_XOR:  f = x ^ y;
        OP_OR:   f = x | y;
        OP_AND:  f = x & y;
        OP_SET:  f = '1;
        default: f = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Sequencer running a W-bit ALU op through one nibble slice, LSB nibble first,
// with a start/ready request side and a one-cycle done pulse.
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2:0]                   op,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  output logic                         ready,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  result,
  output logic                         cout,
  output logic                         ovf,
  output logic                         zero
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              c_q;
  logic [2:0]        op_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      result_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;
  logic              done_q;
  logic              ready_q;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_f;
  logic                nib_cout;
  logic                nib_ovf;
  logic [W-1:0]        result_upd;

  assign nib_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

  alu_nibble u_slice (
    .x    (nib_a),
    .y    (nib_b),
    .cin  (c_q),
    .op   (op_q),
    .f    (nib_f),
    .cout (nib_cout),
    .ovf  (nib_ovf)
  );

  // Result word with the current nibble merged in; zero is judged on this on the last step.
  always_comb begin
    result_upd = result_q;
    result_upd[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = nib_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      c_q      <= 1'b0;
      op_q     <= OP_CLR;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // ready lags the DONE->IDLE step by a cycle, so the done cycle never accepts.
          ready_q <= 1'b1;
          if (start && ready_q) begin
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            result_q <= '0;
            c_q      <= carry_in(op);
            idx_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          result_q <= result_upd;
          c_q      <= nib_cout;
          if (idx_q == IdxLast) begin
            cout_q  <= nib_cout;
            ovf_q   <= nib_ovf;
            zero_q  <= (result_upd == '0);
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq: directed spec cases, handshake, mid-op reset, random ops.
module tb_alu_nibble_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op    = 3'b000;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: whole-word arithmetic on unsigned/signed integers.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int acc);
    exp_t e;
    int   ux, uy, sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    e.res = '0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.acc = acc;
    sr    = 0;
    case (o)
      3'b001: begin
        e.res = y - x;
        e.c   = (uy >= ux);
        sr    = sy - sx;
        e.v   = (sr > 32767) || (sr < -32768);
      end
      3'b010: begin
        e.res = x - y;
        e.c   = (ux >= uy);
        sr    = sx - sy;
        e.v   = (sr > 32767) || (sr < -32768);
      end
      3'b011: begin
        e.res = x + y;
        e.c   = (ux + uy) > 65535;
        sr    = sx + sy;
        e.v   = (sr > 32767) || (sr < -32768);
      end
      3'b100:  e.res = x ^ y;
      3'b101:  e.res = x | y;
      3'b110:  e.res = x & y;
      3'b111:  e.res = 16'hFFFF;
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Monitor: compare on every done pulse, and watch handshake rules.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
        chk("done_expected", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("result", {16'd0, result}, {16'd0, e.res});
          chk("cout", {31'd0, cout}, {31'd0, e.c});
          chk("ovf", {31'd0, ovf}, {31'd0, e.v});
          chk("zero", {31'd0, zero}, {31'd0, e.z});
          chk("latency", cyc - e.acc, NIBBLES + 1);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].acc) begin
        chk("ready_low_busy", {31'd0, ready}, 32'd0);
      end
    end
    prev_done = done;
  end

  // Called at a negedge; returns at a negedge with start dropped and inputs scrambled.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, ready}, 32'd1);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back(model(o, x, y, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(3'b011, 16'h00FF, 16'h0001);
    issue(3'b010, 16'h8000, 16'h0001);
    issue(3'b001, 16'h0005, 16'h0003);
    issue(3'b100, 16'hA5A5, 16'hFFFF);
    issue(3'b111, 16'h1234, 16'h5678);
    issue(3'b000, 16'h1234, 16'h5678);
    issue(3'b011, 16'h7FFF, 16'h0001);
    issue(3'b011, 16'hFFFF, 16'h0001);
    drain();

    // Start held every cycle for 12 cycles: only two get in
    base = done_cnt;
    for (int k = 0; k < 12; k++) begin
      start = 1'b1;
      op    = 3'($urandom);
      a     = 16'($urandom);
      b     = 16'($urandom);
      if (ready === 1'b1) sb.push_back(model(op, a, b, cyc + 1));
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    chk("two_accepts", done_cnt - base, 2);

    // Reset in the middle of an add
    issue(3'b011, 16'h1111, 16'h2222);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #2;
    chk("midrst_result", {16'd0, result}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = done_cnt;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt - base, 0);
    issue(3'b011, 16'h1234, 16'h4321);
    drain();

    // Random ops
    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom), 16'($urandom), 16'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
